// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: takes one K-step of A/B operands per beat and presents them to the
// systolic array with a diagonal skew, then flushes the array and runs the drain window.
module operand_skew_feeder #(
  parameter int unsigned SYS_ARRAY_SIZE = 4,
  parameter int unsigned SIZE           = SYS_ARRAY_SIZE,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned FLUSH_CYCLES   = 2 * SIZE - 1,
  parameter int unsigned DRAIN_CYCLES   = SIZE
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [SIZE-1:0][DATA_W-1:0]   in_a_i,
  input  logic [SIZE-1:0][DATA_W-1:0]   in_b_i,
  input  logic                          in_last_i,
  output logic [SIZE-1:0][DATA_W-1:0]   a_o,
  output logic [SIZE-1:0][DATA_W-1:0]   b_o,
  output logic                          last_o,
  output logic                          ctrl_o,
  output logic                          busy_o,
  output logic                          tile_done_o
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + DRAIN_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             busy_q;
  logic [SIZE-1:0]  last_sr;
  logic             accept;

  // Ready is a pure state decode so it never loops back through in_valid_i.
  assign in_ready_o = (state == S_IDLE) || (state == S_STREAM);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          if (in_last_i) begin
            state_next = S_FLUSH;
            cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_next = S_STREAM;
          end
        end
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          state_next = S_DRAIN;
          cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == '0) state_next = S_IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      last_sr <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      busy_q  <= (state_next != S_IDLE);
      last_sr <= {last_sr[SIZE-2:0], accept & in_last_i};
    end
  end

  assign busy_o      = busy_q;
  assign last_o      = last_sr[SIZE-1];
  assign ctrl_o      = (state == S_DRAIN);
  assign tile_done_o = (state == S_DRAIN) && (cnt == '0);

  // Lane i is an (i+1)-deep shift register packed into one vector; bubbles shift in zeros.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    localparam int unsigned W = (i + 1) * DATA_W;
    logic [W-1:0]      a_sr, b_sr;
    logic [DATA_W-1:0] a_in, b_in;

    assign a_in = accept ? in_a_i[i] : '0;
    assign b_in = accept ? in_b_i[i] : '0;

    always_ff @(posedge clk_i) begin
      // NOTE: skew stages are reset so an aborted tile leaves no stale operands in flight.
      if (rst_i) begin
        a_sr <= '0;
        b_sr <= '0;
      end else begin
        a_sr <= (a_sr << DATA_W) | W'(a_in);
        b_sr <= (b_sr << DATA_W) | W'(b_in);
      end
    end

    assign a_o[i] = a_sr[W-1 -: DATA_W];
    assign b_o[i] = b_sr[W-1 -: DATA_W];
  end

endmodule
